writeback_sequencer: RTL

Multi-cycle writeback controller for the MIPS register file. It accepts a writeback request from the main control unit and waits for memory on loads. It then drives the register-destination selector (00 RT, 01 RD/Inst[15:11], 10 $31) and the write-data selector, and issues a single-cycle reg_write pulse. It suppresses writes to $0 and on arithmetic overflow, and reports completion, overflow and memory-timeout back to the control unit.

---
 rtl/writeback_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_sequencer.sv
// Multi-cycle register-file writeback controller: latches a request, waits for memory on loads,
// drives destination/data selectors and issues a single reg_write pulse followed by wb_done.
module writeback_sequencer #(
    parameter int MEM_TIMEOUT = 8,
    parameter int LINK_REG    = 31
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wb_start,
    input  logic [2:0] wb_kind,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic       alu_overflow,
    input  logic       mem_ready,
    output logic [1:0] seletor_regdest,
    output logic [1:0] seletor_memtoreg,
    output logic       reg_write,
    output logic [4:0] dest_reg,
    output logic       busy,
    output logic       wb_done,
    output logic       ovf_exception,
    output logic       mem_fault,
    output logic       start_dropped
);

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_I    = 3'd1;
    localparam logic [2:0] KIND_LOAD = 3'd2;
    localparam logic [2:0] KIND_JAL  = 3'd3;
    localparam logic [2:0] KIND_LUI  = 3'd4;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [4:0] LINK_IDX     = 5'(LINK_REG);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE,
        DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] kind_reg, kind_next;
    logic       ovf_reg, ovf_next;
    logic       fault_reg, fault_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [4:0] dest_latch_reg, dest_latch_next;

    logic [1:0] regdest_reg, regdest_next;
    logic [1:0] memtoreg_reg, memtoreg_next;
    logic       reg_write_reg, reg_write_next;
    logic [4:0] dest_out_reg, dest_out_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       ovf_exc_reg, ovf_exc_next;
    logic       mem_fault_reg, mem_fault_next;
    logic       dropped_reg, dropped_next;

    logic       ovf_cancel;
    logic       write_ok;

    // Control state and request latches
    always_comb begin
        state_next      = state_reg;
        kind_next       = kind_reg;
        ovf_next        = ovf_reg;
        fault_next      = fault_reg;
        cnt_next        = cnt_reg;
        dest_latch_next = dest_latch_reg;
        case (state_reg)
            IDLE: begin
                if (wb_start) begin
                    kind_next  = wb_kind;
                    ovf_next   = alu_overflow;
                    fault_next = 1'b0;
                    cnt_next   = 8'd0;
                    case (wb_kind)
                        KIND_I, KIND_LOAD, KIND_LUI: dest_latch_next = rt;
                        KIND_JAL:                    dest_latch_next = LINK_IDX;
                        default:                     dest_latch_next = rd;
                    endcase
                    state_next = (wb_kind == KIND_LOAD) ? WAIT_MEM : WRITE;
                end
            end
            WAIT_MEM: begin
                cnt_next = cnt_reg + 8'd1;
                // mem_ready takes priority over an expiring timeout
                if (mem_ready) begin
                    state_next = WRITE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    fault_next = 1'b1;
                    state_next = DONE;
                end
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Overflow only cancels ALU-class writes; reserved kinds behave as R-type but never write
    assign ovf_cancel = ovf_next && ((kind_next == KIND_R) || (kind_next == KIND_I) ||
                                     (kind_next > KIND_LUI));
    assign write_ok   = (kind_next <= KIND_LUI) && (dest_latch_next != 5'd0) && !ovf_cancel;

    // Outputs are computed from the next state so the registered outputs track the state
    always_comb begin
        regdest_next   = 2'b00;
        memtoreg_next  = 2'b00;
        reg_write_next = 1'b0;
        dest_out_next  = 5'd0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        ovf_exc_next   = 1'b0;
        mem_fault_next = 1'b0;
        dropped_next   = wb_start && (state_reg != IDLE);
        if (state_next != IDLE) begin
            busy_next     = 1'b1;
            dest_out_next = dest_latch_next;
            case (kind_next)
                KIND_I:    begin regdest_next = 2'b00; memtoreg_next = 2'b00; end
                KIND_LOAD: begin regdest_next = 2'b00; memtoreg_next = 2'b01; end
                KIND_JAL:  begin regdest_next = 2'b10; memtoreg_next = 2'b10; end
                KIND_LUI:  begin regdest_next = 2'b00; memtoreg_next = 2'b11; end
                default:   begin regdest_next = 2'b01; memtoreg_next = 2'b00; end
            endcase
        end
        if (state_next == WRITE) begin
            reg_write_next = write_ok;
        end
        if (state_next == DONE) begin
            done_next      = 1'b1;
            ovf_exc_next   = ovf_cancel && !fault_next;
            mem_fault_next = fault_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            kind_reg       <= 3'd0;
            ovf_reg        <= 1'b0;
            fault_reg      <= 1'b0;
            cnt_reg        <= 8'd0;
            dest_latch_reg <= 5'd0;
            regdest_reg    <= 2'b00;
            memtoreg_reg   <= 2'b00;
            reg_write_reg  <= 1'b0;
            dest_out_reg   <= 5'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            ovf_exc_reg    <= 1'b0;
            mem_fault_reg  <= 1'b0;
            dropped_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            kind_reg       <= kind_next;
            ovf_reg        <= ovf_next;
            fault_reg      <= fault_next;
            cnt_reg        <= cnt_next;
            dest_latch_reg <= dest_latch_next;
            regdest_reg    <= regdest_next;
            memtoreg_reg   <= memtoreg_next;
            reg_write_reg  <= reg_write_next;
            dest_out_reg   <= dest_out_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            ovf_exc_reg    <= ovf_exc_next;
            mem_fault_reg  <= mem_fault_next;
            dropped_reg    <= dropped_next;
        end
    end

    assign seletor_regdest  = regdest_reg;
    assign seletor_memtoreg = memtoreg_reg;
    assign reg_write        = reg_write_reg;
    assign dest_reg         = dest_out_reg;
    assign busy             = busy_reg;
    assign wb_done          = done_reg;
    assign ovf_exception    = ovf_exc_reg;
    assign mem_fault        = mem_fault_reg;
    assign start_dropped    = dropped_reg;

endmodule
